// File: rtl/de_pipe_reg_pkg.sv
// Shared definitions for the pipeline stage registers: NOP encoding, reset PC,
// Tnew width and the Tnew hand-over helper.
package de_pipe_reg_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam int          TNEW_W           = 2;

   typedef logic [TNEW_W-1:0] tnew_t;

   // One stage later a pending result is one cycle closer; floor at zero.
   function automatic tnew_t tnew_dec(input tnew_t t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/de_pipe_reg_sat_counter.sv
// Saturating incrementer with asynchronous active-high reset, shared by the
// stage registers' perf counters.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/de_pipe_reg.sv
// Decode-to-Execute pipeline register: captures the D bundle each edge, turns a
// hazard stall into a NOP bubble, and counts inserted bubbles.
module de_pipe_reg
   import de_pipe_reg_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             D_valid,
   input  logic [31:0]      D_pc,
   input  logic [31:0]      D_instr,
   input  logic [31:0]      D_rs_data,
   input  logic [31:0]      D_rt_data,
   input  logic [15:0]      D_imm16,
   input  logic [25:0]      D_imm26,
   input  logic [4:0]       D_A3,
   input  logic [1:0]       D_Tnew,
   output logic             E_valid,
   output logic [31:0]      E_pc,
   output logic [31:0]      E_instr,
   output logic [31:0]      E_rs_data,
   output logic [31:0]      E_rt_data,
   output logic [15:0]      E_imm16,
   output logic [25:0]      E_imm26,
   output logic [4:0]       E_A3,
   output logic [1:0]       E_Tnew,
   output logic [CNT_W-1:0] bubble_cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         E_valid   <= 1'b0;
         E_pc      <= PC_RESET;
         E_instr   <= NOP_INSTR;
         E_rs_data <= '0;
         E_rt_data <= '0;
         E_imm16   <= '0;
         E_imm26   <= '0;
         E_A3      <= '0;
         E_Tnew    <= '0;
      end else if (stall) begin
         // Bubble keeps the held instruction's PC so traces show where E stalled.
         E_valid   <= 1'b0;
         E_pc      <= D_pc;
         E_instr   <= NOP_INSTR;
         E_rs_data <= '0;
         E_rt_data <= '0;
         E_imm16   <= '0;
         E_imm26   <= '0;
         E_A3      <= '0;
         E_Tnew    <= '0;
      end else begin
         E_valid   <= D_valid;
         E_pc      <= D_pc;
         E_instr   <= D_instr;
         E_rs_data <= D_rs_data;
         E_rt_data <= D_rt_data;
         E_imm16   <= D_imm16;
         E_imm26   <= D_imm26;
         // An invalid slot must never claim a write-back target.
         E_A3      <= D_valid ? D_A3 : 5'd0;
         E_Tnew    <= tnew_dec(D_Tnew);
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall),
      .count (bubble_cnt)
   );

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg; a second instance with a 4-bit counter
// exercises bubble counter saturation on the same stimulus.
module tb_de_pipe_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        D_valid = 1'b0;
   logic [31:0] D_pc = '0, D_instr = '0, D_rs_data = '0, D_rt_data = '0;
   logic [15:0] D_imm16 = '0;
   logic [25:0] D_imm26 = '0;
   logic [4:0]  D_A3 = '0;
   logic [1:0]  D_Tnew = '0;

   logic        E_valid;
   logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data;
   logic [15:0] E_imm16;
   logic [25:0] E_imm26;
   logic [4:0]  E_A3;
   logic [1:0]  E_Tnew;
   logic [31:0] bubble_cnt;

   logic        s_valid;
   logic [31:0] s_pc, s_instr, s_rs_data, s_rt_data;
   logic [15:0] s_imm16;
   logic [25:0] s_imm26;
   logic [4:0]  s_A3;
   logic [1:0]  s_Tnew;
   logic [3:0]  s_bubble_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   de_pipe_reg dut (
      .clk(clk), .reset(reset), .stall(stall), .D_valid(D_valid), .D_pc(D_pc),
      .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
      .D_imm16(D_imm16), .D_imm26(D_imm26), .D_A3(D_A3), .D_Tnew(D_Tnew),
      .E_valid(E_valid), .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data),
      .E_rt_data(E_rt_data), .E_imm16(E_imm16), .E_imm26(E_imm26), .E_A3(E_A3),
      .E_Tnew(E_Tnew), .bubble_cnt(bubble_cnt)
   );

   de_pipe_reg #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .stall(stall), .D_valid(D_valid), .D_pc(D_pc),
      .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
      .D_imm16(D_imm16), .D_imm26(D_imm26), .D_A3(D_A3), .D_Tnew(D_Tnew),
      .E_valid(s_valid), .E_pc(s_pc), .E_instr(s_instr), .E_rs_data(s_rs_data),
      .E_rt_data(s_rt_data), .E_imm16(s_imm16), .E_imm26(s_imm26), .E_A3(s_A3),
      .E_Tnew(s_Tnew), .bubble_cnt(s_bubble_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bubble(input string tag, input logic [31:0] pc);
      check({tag, " valid"}, {31'd0, E_valid}, 32'd0);
      check({tag, " pc"},    E_pc,             pc);
      check({tag, " instr"}, E_instr,          32'd0);
      check({tag, " rs"},    E_rs_data,        32'd0);
      check({tag, " imm16"}, {16'd0, E_imm16}, 32'd0);
      check({tag, " A3"},    {27'd0, E_A3},    32'd0);
      check({tag, " Tnew"},  {30'd0, E_Tnew},  32'd0);
   endtask

   initial begin
      // Asynchronous reset from power-up, away from any edge.
      #1 reset = 1'b1;
      #1;
      check("rst valid", {31'd0, E_valid}, 32'd0);
      check("rst pc",    E_pc,             32'h0000_3000);
      check("rst instr", E_instr,          32'd0);
      check("rst rt",    E_rt_data,        32'd0);
      check("rst imm26", {6'd0, E_imm26},  32'd0);
      check("rst A3",    {27'd0, E_A3},    32'd0);
      check("rst cnt",   bubble_cnt,       32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Plain capture: lui $1, 0x1234.
      D_valid = 1'b1;  D_pc = 32'h0000_3004;  D_instr = 32'h3C01_1234;
      D_rs_data = 32'h1111_1111;  D_rt_data = 32'h2222_2222;
      D_imm16 = 16'h1234;  D_imm26 = 26'h001_1234;  D_A3 = 5'd1;  D_Tnew = 2'd2;
      step();
      check("cap valid", {31'd0, E_valid}, 32'd1);
      check("cap pc",    E_pc,             32'h0000_3004);
      check("cap instr", E_instr,          32'h3C01_1234);
      check("cap rs",    E_rs_data,        32'h1111_1111);
      check("cap rt",    E_rt_data,        32'h2222_2222);
      check("cap imm16", {16'd0, E_imm16}, 32'h0000_1234);
      check("cap imm26", {6'd0, E_imm26},  32'h0001_1234);
      check("cap A3",    {27'd0, E_A3},    32'd1);
      check("cap Tnew",  {30'd0, E_Tnew},  32'd1);
      check("cap cnt",   bubble_cnt,       32'd0);

      // Three consecutive stalls on the held instruction.
      stall = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         check_bubble("stall", 32'h0000_3004);
         check("stall cnt", bubble_cnt, 32'(i));
      end

      // Release loads the held instruction.
      stall = 1'b0;
      step();
      check("rel valid", {31'd0, E_valid}, 32'd1);
      check("rel instr", E_instr,          32'h3C01_1234);
      check("rel A3",    {27'd0, E_A3},    32'd1);
      check("rel Tnew",  {30'd0, E_Tnew},  32'd1);
      check("rel cnt",   bubble_cnt,       32'd3);

      // Tnew floor and decrement.
      D_Tnew = 2'd0;  step();  check("tnew0", {30'd0, E_Tnew}, 32'd0);
      D_Tnew = 2'd1;  step();  check("tnew1", {30'd0, E_Tnew}, 32'd0);
      D_Tnew = 2'd3;  step();  check("tnew3", {30'd0, E_Tnew}, 32'd2);

      // Invalid D slot: payload captured, write-back suppressed.
      D_valid = 1'b0;  D_A3 = 5'd5;  D_pc = 32'h0000_3010;  D_instr = 32'h8C22_0004;
      D_imm16 = 16'h0004;
      step();
      check("inv valid", {31'd0, E_valid}, 32'd0);
      check("inv A3",    {27'd0, E_A3},    32'd0);
      check("inv pc",    E_pc,             32'h0000_3010);
      check("inv instr", E_instr,          32'h8C22_0004);
      check("inv imm16", {16'd0, E_imm16}, 32'h0000_0004);
      check("inv Tnew",  {30'd0, E_Tnew},  32'd2);

      // Stall with invalid D still counts.
      stall = 1'b1;
      step();
      check_bubble("istall", 32'h0000_3010);
      check("istall cnt", bubble_cnt,   32'd4);
      check("istall sat", {28'd0, s_bubble_cnt}, 32'd4);

      // Drive the 4-bit counter to saturation and past it: 20 stalls total.
      for (int i = 0; i < 11; i++) step();
      check("sat15 cnt", {28'd0, s_bubble_cnt}, 32'h0000_000F);
      for (int i = 0; i < 9; i++) step();
      check("sat hold",  {28'd0, s_bubble_cnt}, 32'h0000_000F);
      check("wide cnt",  bubble_cnt,            32'd24);
      check("sat pc",    E_pc,                  32'h0000_3010);

      // Reset in the middle of a stall, between edges.
      #2 reset = 1'b1;
      #1;
      check("mrst cnt",  bubble_cnt,            32'd0);
      check("mrst sat",  {28'd0, s_bubble_cnt}, 32'd0);
      check("mrst pc",   E_pc,                  32'h0000_3000);
      check("mrst valid",{31'd0, E_valid},      32'd0);

      // First edge after release is a normal capture.
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b0;
      D_valid = 1'b1;  D_pc = 32'h0000_3020;  D_instr = 32'h2401_0007;  D_A3 = 5'd1;
      D_Tnew = 2'd1;
      step();
      check("post valid", {31'd0, E_valid}, 32'd1);
      check("post pc",    E_pc,             32'h0000_3020);
      check("post instr", E_instr,          32'h2401_0007);
      check("post A3",    {27'd0, E_A3},    32'd1);
      check("post cnt",   bubble_cnt,       32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
